// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and entry type for the fetch stage
package if_fetch_unit_pkg;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [31:0]       pc_plus_one;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Zero-extend before adding so 0xFF yields 0x100 rather than wrapping.
  function automatic logic [31:0] calc_pc_plus_one(input logic [ADDR_W-1:0] pc);
    return 32'(pc) + 32'd1;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - redirect, instruction-memory and IF/ID handshake bundle
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [31:0]       out_pc_plus_one;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, out_valid, out_instr, out_pc_plus_one
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc_plus_one
  );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// rtl/if_fetch_unit_fifo.sv - synchronous FIFO of fetched words with flush
module fetch_fifo
  import if_fetch_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             head_valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);

  // Upstream credit accounting keeps push from ever seeing a full FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_o       = head_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch PC, request credits, tag queue and redirect drop logic
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  if_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0] tag_q [DEPTH];
  logic [PTR_W-1:0]  tag_wr_q, tag_rd_q;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              redirect, issue_ok, issue, rsp, rsp_keep, pop;
  fetch_entry_t      push_data, head;
  logic              head_valid;

  assign redirect    = bus.redirect_valid && !reset_i;
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign issue_ok    = !reset_i && !bus.redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
  assign issue       = issue_ok && bus.imem_ready;
  assign rsp         = bus.imem_rvalid && !reset_i;
  // Responses are kept only in RUN mode; the redirect cycle always discards.
  assign rsp_keep    = rsp && !redirect && (drop_cnt_q == '0);
  assign pop         = head_valid && !bus.stall && !redirect;

  assign bus.imem_req  = issue_ok;
  assign bus.imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp);
    drop_cnt_d    = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = bus.redirect_pc;
      drop_cnt_d = outstanding_d;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 1'b1;
      end
      if (rsp && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if (redirect) begin
        tag_wr_q <= '0;
        tag_rd_q <= '0;
      end else begin
        if (issue) begin
          tag_q[tag_wr_q] <= fetch_pc_q;
          tag_wr_q        <= tag_wr_q + 1'b1;
        end
        if (rsp_keep) begin
          tag_rd_q <= tag_rd_q + 1'b1;
        end
      end
    end
  end

  assign push_data.pc_plus_one = calc_pc_plus_one(tag_q[tag_rd_q]);
  assign push_data.instr       = bus.imem_rdata;

  fetch_fifo u_fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (redirect),
    .push_i       (rsp_keep),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (fifo_count)
  );

  assign bus.out_valid       = head_valid;
  assign bus.out_instr       = head.instr;
  assign bus.out_pc_plus_one = head.pc_plus_one;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with a latency-programmable imem
module tb_if_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   lat   = 1;
  int   cyc   = 0;
  int         pend_due  [$];
  logic [7:0] pend_addr [$];

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [7:0] a);
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // In-order memory: a request accepted in cycle c answers in cycle c+lat.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        pend_due.delete();
        pend_addr.delete();
      end else if (bus.imem_req && bus.imem_ready) begin
        pend_due.push_back(cyc + lat);
        pend_addr.push_back(bus.imem_addr);
      end
      cyc++;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end
    end
  end

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.stall          = 1'b0;
    bus.imem_ready     = 1'b1;
    lat                = 1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc1", bus.out_pc_plus_one, 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);

    // Streaming with a single-cycle memory.
    reset = 1'b0;
    #1;
    chk("t1_req", 32'(bus.imem_req), 32'd1);
    chk("t1_addr0", 32'(bus.imem_addr), 32'd0);
    tick();
    chk("t1_empty", 32'(bus.out_valid), 32'd0);
    chk("t1_addr1", 32'(bus.imem_addr), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_pc1", bus.out_pc_plus_one, 32'(i + 1));
      chk("t1_instr", bus.out_instr, word(8'(i)));
      tick();
    end

    // Long stall: credits run out, nothing lost on release.
    bus.stall = 1'b1;
    repeat (7) tick();
    chk("t2_req_off", 32'(bus.imem_req), 32'd0);
    chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_hold_pc1", bus.out_pc_plus_one, 32'd4);
    tick();
    bus.stall = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      chk("t2_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_pc1", bus.out_pc_plus_one, 32'(4 + j));
      chk("t2_instr", bus.out_instr, word(8'(3 + j)));
      tick();
    end

    // Latency 3, redirect with two requests in flight.
    reset = 1'b1;
    lat   = 3;
    tick();
    reset = 1'b0;
    #1;
    chk("t3_addr0", 32'(bus.imem_addr), 32'd0);
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    #1;
    chk("t3_req_redir", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_req_new", 32'(bus.imem_req), 32'd1);
    chk("t3_addr_new", 32'(bus.imem_addr), 32'h40);
    chk("t3_flushed", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_dropped", 32'(bus.out_valid), 32'd0);
    end
    tick();
    chk("t3_first_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_first_pc1", bus.out_pc_plus_one, 32'h41);
    chk("t3_first_instr", bus.out_instr, word(8'h40));
    tick();
    chk("t3_second_pc1", bus.out_pc_plus_one, 32'h42);
    chk("t3_second_instr", bus.out_instr, word(8'h41));

    // Redirect coinciding with a response and a stall.
    reset = 1'b1;
    lat   = 1;
    tick();
    reset = 1'b0;
    #1;
    tick();
    tick();
    tick();
    chk("t4_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_pre_pc1", bus.out_pc_plus_one, 32'd2);
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h80;
    #1;
    chk("t4_req_redir", 32'(bus.imem_req), 32'd0);
    tick();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_flushed", 32'(bus.out_valid), 32'd0);
    chk("t4_req_new", 32'(bus.imem_req), 32'd1);
    chk("t4_addr_new", 32'(bus.imem_addr), 32'h80);
    tick();
    chk("t4_wait", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t4_first_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_first_pc1", bus.out_pc_plus_one, 32'h81);
    chk("t4_first_instr", bus.out_instr, word(8'h80));

    // PC wrap at the top of the address space, then a refused request.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFF;
    #1;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_addr_ff", 32'(bus.imem_addr), 32'hFF);
    tick();
    chk("t5_addr_wrap", 32'(bus.imem_addr), 32'h00);
    tick();
    chk("t5_pc1_ff", bus.out_pc_plus_one, 32'h100);
    chk("t5_instr_ff", bus.out_instr, word(8'hFF));
    tick();
    chk("t5_pc1_00", bus.out_pc_plus_one, 32'h1);
    chk("t5_instr_00", bus.out_instr, word(8'h00));
    bus.imem_ready = 1'b0;
    #1;
    chk("t5_addr_02", 32'(bus.imem_addr), 32'h02);
    tick();
    chk("t5_addr_held", 32'(bus.imem_addr), 32'h02);
    chk("t5_pc1_01", bus.out_pc_plus_one, 32'h2);
    bus.imem_ready = 1'b1;
    tick();
    chk("t5_bubble", 32'(bus.out_valid), 32'd0);

    // Reset with words buffered and requests in flight.
    reset     = 1'b1;
    lat       = 3;
    bus.stall = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    repeat (5) tick();
    chk("t6_buf_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_buf_pc1", bus.out_pc_plus_one, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_req_rst", 32'(bus.imem_req), 32'd0);
    tick();
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_instr", bus.out_instr, 32'd0);
    chk("t6_rst_pc1", bus.out_pc_plus_one, 32'd0);
    bus.stall = 1'b0;
    reset     = 1'b0;
    #1;
    chk("t6_restart_req", 32'(bus.imem_req), 32'd1);
    chk("t6_restart_addr", 32'(bus.imem_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_stale", 32'(bus.out_valid), 32'd0);
    end
    tick();
    chk("t6_first_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_first_pc1", bus.out_pc_plus_one, 32'd1);
    chk("t6_first_instr", bus.out_instr, word(8'h00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
